// File: rtl/grid_render.sv
// Two-stage tile-grid pixel renderer; board and overlay are shadowed on each vsync rise.
// Optional GRID_RENDER_GRIDLINE_EN draws dark lines on the first pixel row/column of each cell.
module grid_render #(
   parameter int CELL_LOG2 = 5,
   parameter int COLS      = 10,
   parameter int ROWS      = 20,
   parameter int ORG_X     = 0,
   parameter int ORG_Y     = 0,
   parameter int NOVL      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_vs,
   input  logic                     i_hs,
   input  logic                     i_de,
   input  logic [COLS*ROWS*4-1:0]   i_board,
   input  logic [NOVL*5-1:0]        i_ovl_x,
   input  logic [NOVL*5-1:0]        i_ovl_y,
   input  logic [3:0]               i_ovl_code,
   output logic                     o_vs,
   output logic                     o_hs,
   output logic                     o_de,
   output logic [7:0]               o_red,
   output logic [7:0]               o_grn,
   output logic [7:0]               o_blu
);

   localparam logic [10:0] CNT_MAX    = 11'h7FF;
   localparam logic [23:0] BORDER_RGB = 24'hC8C8C8;

   logic [10:0]            x, y;
   logic                   vs1, hs1, de1;
   logic                   loaded;
   logic [COLS*ROWS*4-1:0] board_sh;
   logic [NOVL*5-1:0]      ovx_sh, ovy_sh;
   logic [3:0]             code_sh;
   logic [4:0]             cx1, cy1;
   logic                   inside1;

   logic [10:0]            dx, dy, cx_full, cy_full;
   logic                   inside_c;

`ifdef GRID_RENDER_GRIDLINE_EN
   localparam logic [23:0] GRID_RGB = 24'h404040;
   logic                   edge1;
`endif

   function automatic logic [23:0] palette(input logic [3:0] c);
      case (c)
         4'd0:    palette = 24'h000000;
         4'd1:    palette = 24'h00FFFF;
         4'd2:    palette = 24'hFFFF00;
         4'd3:    palette = 24'hFF00FF;
         4'd4:    palette = 24'hFF7F00;
         4'd5:    palette = 24'h0000FF;
         4'd6:    palette = 24'h00FF00;
         4'd7:    palette = 24'hFF0000;
         default: palette = 24'h7F7F7F;
      endcase
   endfunction

   always_comb begin
      dx       = x - 11'(ORG_X);
      dy       = y - 11'(ORG_Y);
      cx_full  = dx >> CELL_LOG2;
      cy_full  = dy >> CELL_LOG2;
      inside_c = (x >= 11'(ORG_X)) && (y >= 11'(ORG_Y)) &&
                 (cx_full < 11'(COLS)) && (cy_full < 11'(ROWS));
   end

   // Counters, shadows and stage 1; the shadows only move on a vsync rise so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x        <= '0;
         y        <= '0;
         vs1      <= 1'b0;
         hs1      <= 1'b0;
         de1      <= 1'b0;
         loaded   <= 1'b0;
         board_sh <= '0;
         ovx_sh   <= '0;
         ovy_sh   <= '0;
         code_sh  <= '0;
         cx1      <= '0;
         cy1      <= '0;
         inside1  <= 1'b0;
`ifdef GRID_RENDER_GRIDLINE_EN
         edge1    <= 1'b0;
`endif
      end else begin
         vs1 <= i_vs;
         hs1 <= i_hs;
         de1 <= i_de;
         if (!i_de)
            x <= '0;
         else if (x != CNT_MAX)
            x <= x + 11'd1;
         if (i_vs)
            y <= '0;
         else if (de1 && !i_de && y != CNT_MAX)
            y <= y + 11'd1;
         if (i_vs && !vs1) begin
            board_sh <= i_board;
            ovx_sh   <= i_ovl_x;
            ovy_sh   <= i_ovl_y;
            code_sh  <= i_ovl_code;
            loaded   <= 1'b1;
         end
         cx1     <= cx_full[4:0];
         cy1     <= cy_full[4:0];
         inside1 <= inside_c;
`ifdef GRID_RENDER_GRIDLINE_EN
         edge1   <= (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
`endif
      end
   end

   logic [3:0]  board_cell;
   logic        ovl_hit;
   logic [3:0]  code;
   logic [23:0] rgb_c;

   // Cell code resolution: overlays outside the grid can never match, then overlay beats board.
   always_comb begin
      board_cell = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (cy1 == 5'(r) && cx1 == 5'(c))
               board_cell = board_sh[(r*COLS+c)*4 +: 4];
      ovl_hit = 1'b0;
      for (int k = 0; k < NOVL; k++)
         if (ovx_sh[5*k +: 5] < 5'(COLS) && ovy_sh[5*k +: 5] < 5'(ROWS) &&
             ovx_sh[5*k +: 5] == cx1 && ovy_sh[5*k +: 5] == cy1)
            ovl_hit = 1'b1;
      code  = ovl_hit ? code_sh : board_cell;
      rgb_c = '0;
      if (!de1 || !loaded)
         rgb_c = '0;
      else if (!inside1)
         rgb_c = BORDER_RGB;
`ifdef GRID_RENDER_GRIDLINE_EN
      else if (edge1)
         rgb_c = GRID_RGB;
      else
         rgb_c = palette(code);
`else
      else
         rgb_c = palette(code);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vs  <= 1'b0;
         o_hs  <= 1'b0;
         o_de  <= 1'b0;
         o_red <= '0;
         o_grn <= '0;
         o_blu <= '0;
      end else begin
         o_vs  <= vs1;
         o_hs  <= hs1;
         o_de  <= de1;
         o_red <= rgb_c[23:16];
         o_grn <= rgb_c[15:8];
         o_blu <= rgb_c[7:0];
      end
   end

endmodule

// File: tb/tb_grid_render.sv
// Bench for grid_render: a pixel-coordinate reference model checked every cycle on two instances
// (default placement, and ORG_X=64 with COLS=4), plus literal pixel expectations.
`timescale 1ns/1ps
module tb_grid_render;

   localparam int ROWS   = 20;
   localparam int COLS_A = 10;
   localparam int COLS_B = 4;
   localparam int NOVL   = 4;
   localparam logic [23:0] BORDER = 24'hC8C8C8;
   localparam logic [23:0] GRID   = 24'h404040;
`ifdef GRID_RENDER_GRIDLINE_EN
   localparam bit GL_ON = 1'b1;
`else
   localparam bit GL_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
   logic [COLS_A*ROWS*4-1:0] board_a;
   logic [COLS_B*ROWS*4-1:0] board_b;
   logic [NOVL*5-1:0] ovl_x, ovl_y;
   logic [3:0] ovl_code;
   logic vs_a, hs_a, de_a, vs_b, hs_b, de_b;
   logic [7:0] red_a, grn_a, blu_a, red_b, grn_b, blu_b;

   always #5 clk = ~clk;

   grid_render dut_a (
      .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
      .i_board(board_a), .i_ovl_x(ovl_x), .i_ovl_y(ovl_y), .i_ovl_code(ovl_code),
      .o_vs(vs_a), .o_hs(hs_a), .o_de(de_a), .o_red(red_a), .o_grn(grn_a), .o_blu(blu_a)
   );

   grid_render #(.ORG_X(64), .COLS(COLS_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
      .i_board(board_b), .i_ovl_x(ovl_x), .i_ovl_y(ovl_y), .i_ovl_code(ovl_code),
      .o_vs(vs_b), .o_hs(hs_b), .o_de(de_b), .o_red(red_b), .o_grn(grn_b), .o_blu(blu_b)
   );

   // Live inputs as the bench sees them, and the per-frame copies the display must show.
   logic [3:0] live_a [ROWS][COLS_A];
   logic [3:0] live_b [ROWS][COLS_B];
   logic [4:0] live_ovx [NOVL];
   logic [4:0] live_ovy [NOVL];
   logic [3:0] live_code;
   logic [3:0] frm_a [ROWS][COLS_A];
   logic [3:0] frm_b [ROWS][COLS_B];
   logic [4:0] frm_ovx [NOVL];
   logic [4:0] frm_ovy [NOVL];
   logic [3:0] frm_code;
   bit m_loaded = 1'b0;
   bit prev_vs = 1'b0;
   int cur_px = 0, cur_py = 0, cur_phase = 99;

   int tests = 0;
   int fails = 0;

   always_comb begin
      board_a = '0;
      board_b = '0;
      ovl_x   = '0;
      ovl_y   = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS_A; c++) board_a[(r*COLS_A+c)*4 +: 4] = live_a[r][c];
         for (int c = 0; c < COLS_B; c++) board_b[(r*COLS_B+c)*4 +: 4] = live_b[r][c];
      end
      for (int k = 0; k < NOVL; k++) begin
         ovl_x[5*k +: 5] = live_ovx[k];
         ovl_y[5*k +: 5] = live_ovy[k];
      end
      ovl_code = live_code;
   end

   function automatic logic [23:0] pal(input logic [3:0] c);
      case (c)
         4'd0:    return 24'h000000;
         4'd1:    return 24'h00FFFF;
         4'd2:    return 24'hFFFF00;
         4'd3:    return 24'hFF00FF;
         4'd4:    return 24'hFF7F00;
         4'd5:    return 24'h0000FF;
         4'd6:    return 24'h00FF00;
         4'd7:    return 24'hFF0000;
         default: return 24'h7F7F7F;
      endcase
   endfunction

   // Colour of screen pixel (px,py) for one instance, from the frame copies.
   function automatic logic [23:0] model_rgb(input bit is_b, input int px, input int py);
      int org, cols, dx, cx, cy;
      logic [3:0] code;
      org  = is_b ? 64 : 0;
      cols = is_b ? COLS_B : COLS_A;
      if (!m_loaded || !i_de) return 24'h0;
      if (px < org) return BORDER;
      dx = px - org;
      cx = dx / 32;
      cy = py / 32;
      if (cx >= cols || cy >= ROWS) return BORDER;
      if (GL_ON && (dx % 32 == 0 || py % 32 == 0)) return GRID;
      for (int k = 0; k < NOVL; k++)
         if (int'(frm_ovx[k]) == cx && int'(frm_ovy[k]) == cy) return pal(frm_code);
      code = is_b ? frm_b[cy][cx] : frm_a[cy][cx];
      return pal(code);
   endfunction

   typedef struct packed {
      logic        vs, hs, de;
      logic [23:0] rgb_a, rgb_b;
      logic [15:0] px, py;
      logic [7:0]  phase;
   } exp_t;

   exp_t pipe1, pipe2;

   function automatic exp_t make_exp();
      exp_t e;
      e.vs    = i_vs;
      e.hs    = i_hs;
      e.de    = i_de;
      e.rgb_a = model_rgb(1'b0, cur_px, cur_py);
      e.rgb_b = model_rgb(1'b1, cur_px, cur_py);
      e.px    = 16'(cur_px);
      e.py    = 16'(cur_py);
      e.phase = 8'(cur_phase);
      return e;
   endfunction

   // Two-pixel output latency of the reference.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe1 <= '0;
         pipe2 <= '0;
      end else begin
         pipe2 <= pipe1;
         pipe1 <= make_exp();
      end
   end

   int lit_phase [32];
   bit lit_b     [32];
   int lit_px    [32];
   int lit_py    [32];
   logic [23:0] lit_rgb [32];
   bit lit_hit   [32];
   int nlit = 0;

   task automatic addLit(input int ph, input bit b, input int px, input int py, input logic [23:0] rgb);
      lit_phase[nlit] = ph;
      lit_b[nlit]     = b;
      lit_px[nlit]    = px;
      lit_py[nlit]    = py;
      lit_rgb[nlit]   = rgb;
      lit_hit[nlit]   = 1'b0;
      nlit++;
   endtask

   task automatic checkOutput();
      logic [26:0] got, exp;
      logic [23:0] lgot;
      got = {vs_a, hs_a, de_a, red_a, grn_a, blu_a};
      exp = {pipe2.vs, pipe2.hs, pipe2.de, pipe2.rgb_a};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL outA phase=%0d px=%0d py=%0d got=%h exp=%h", pipe2.phase, pipe2.px, pipe2.py, got, exp);
      end
      got = {vs_b, hs_b, de_b, red_b, grn_b, blu_b};
      exp = {pipe2.vs, pipe2.hs, pipe2.de, pipe2.rgb_b};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL outB phase=%0d px=%0d py=%0d got=%h exp=%h", pipe2.phase, pipe2.px, pipe2.py, got, exp);
      end
      for (int i = 0; i < nlit; i++)
         if (pipe2.de && int'(pipe2.phase) == lit_phase[i] && int'(pipe2.px) == lit_px[i] &&
             int'(pipe2.py) == lit_py[i]) begin
            lit_hit[i] = 1'b1;
            lgot = lit_b[i] ? {red_b, grn_b, blu_b} : {red_a, grn_a, blu_a};
            tests++;
            if (lgot !== lit_rgb[i]) begin
               fails++;
               $display("[TB] FAIL lit%0d phase=%0d px=%0d py=%0d got=%h exp=%h",
                        i, lit_phase[i], lit_px[i], lit_py[i], lgot, lit_rgb[i]);
            end
         end
   endtask

   always @(negedge clk) checkOutput();

   task automatic applyStimulus(input logic vs, input logic hs, input logic de, input int px, input int py);
      i_vs   = vs;
      i_hs   = hs;
      i_de   = de;
      cur_px = px;
      cur_py = py;
      if (vs && !prev_vs) begin
         frm_a    = live_a;
         frm_b    = live_b;
         frm_ovx  = live_ovx;
         frm_ovy  = live_ovy;
         frm_code = live_code;
         m_loaded = 1'b1;
      end
      prev_vs = vs;
      @(posedge clk);
      #1;
   endtask

   task automatic driveLine(input int py, input int width, input int rst_at);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, py);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, py);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, py);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, py);
      for (int p = 0; p < width; p++) begin
         if (rst_at >= 0 && p == rst_at) begin
            rst_n    = 1'b0;
            m_loaded = 1'b0;
            prev_vs  = 1'b0;
         end
         if (rst_at >= 0 && p == rst_at + 3) rst_n = 1'b1;
         applyStimulus(1'b0, 1'b0, 1'b1, p, py);
      end
   endtask

   task automatic runFrame(input int nlines, input int width, input int phase, input bit change100);
      cur_phase = phase;
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      for (int l = 0; l < nlines; l++) begin
         if (change100 && l == 100) begin
            live_a[0][0] = 4'd5;
            live_a[3][0] = 4'd5;
         end
         driveLine(l, width, -1);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS_A; c++) live_a[r][c] = 4'd0;
         for (int c = 0; c < COLS_B; c++) live_b[r][c] = 4'd0;
      end
      for (int k = 0; k < NOVL; k++) begin
         live_ovx[k] = 5'd31;
         live_ovy[k] = 5'd31;
      end
      live_code    = 4'd0;
      live_b[0][0] = 4'd2;
      live_b[0][3] = 4'd6;

      addLit(5, 1'b0, 330, 0, 24'h000000);
      addLit(0, 1'b0, 0, 0, GL_ON ? GRID : 24'h000000);
      addLit(0, 1'b0, 5, 1, 24'h000000);
      addLit(0, 1'b0, 320, 0, BORDER);
      addLit(1, 1'b0, 97, 65, 24'h00FFFF);
      addLit(1, 1'b0, 127, 95, 24'h00FFFF);
      addLit(1, 1'b0, 96, 64, GL_ON ? GRID : 24'h00FFFF);
      addLit(1, 1'b0, 129, 70, 24'h000000);
      addLit(1, 1'b0, 32, 40, GL_ON ? GRID : 24'hFF00FF);
      addLit(1, 1'b0, 33, 40, 24'hFF00FF);
      addLit(1, 1'b0, 1, 1, 24'h000000);
      addLit(1, 1'b0, 1, 100, 24'h000000);
      addLit(1, 1'b1, 63, 1, BORDER);
      addLit(1, 1'b1, 64, 1, GL_ON ? GRID : 24'hFFFF00);
      addLit(1, 1'b1, 65, 1, 24'hFFFF00);
      addLit(1, 1'b1, 191, 1, 24'h00FF00);
      addLit(1, 1'b1, 192, 1, BORDER);
      addLit(2, 1'b0, 1, 1, 24'h0000FF);
      addLit(3, 1'b0, 510, 0, 24'h000000);
      addLit(3, 1'b0, 330, 1, 24'h000000);
      addLit(4, 1'b0, 1, 1, 24'h0000FF);
      addLit(4, 1'b0, 320, 1, BORDER);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      cur_phase = 5;
      driveLine(0, 340, -1);
      runFrame(2, 340, 0, 1'b0);

      live_a[2][3] = 4'd7;
      live_a[1][1] = 4'd3;
      live_ovx[0]  = 5'd3;
      live_ovy[0]  = 5'd2;
      live_code    = 4'd1;
      runFrame(101, 340, 1, 1'b1);
      runFrame(2, 340, 2, 1'b0);

      cur_phase = 3;
      driveLine(0, 520, 500);
      driveLine(1, 340, -1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      runFrame(2, 340, 4, 1'b0);

      for (int i = 0; i < nlit; i++) begin
         tests++;
         if (!lit_hit[i]) begin
            fails++;
            $display("[TB] FAIL litSeen%0d got=0 exp=1", i);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/grid_render.md
GRID_RENDER -- requirements
Module: grid_render

Interface
REQ-001 SHALL have parameter CELL_LOG2, default 5, meaning log2 of cell edge in pixels (cell = 32x32).
REQ-002 SHALL have parameter COLS, default 10, meaning grid width in cells (1..31).
REQ-003 SHALL have parameter ROWS, default 20, meaning grid height in cells (1..31).
REQ-004 SHALL have parameters ORG_X and ORG_Y, default 0, meaning pixel position of the grid top-left corner.
REQ-005 SHALL have parameter NOVL, default 4, meaning number of overlay (falling-piece) cells.
REQ-006 SHALL have clk input 1, the pixel clock.
REQ-007 SHALL have rst_n input 1, asynchronous active-low reset.
REQ-008 SHALL have i_vs, i_hs and i_de inputs 1 each, active-high timing syncs.
REQ-009 SHALL have i_board input COLS*ROWS*4, with the 4-bit cell code of cell (c,r) at bit offset (r*COLS+c)*4.
REQ-010 SHALL have i_ovl_x and i_ovl_y inputs NOVL*5 each, overlay cell coordinates, with entry k at bits [5k+:5].
REQ-011 SHALL have i_ovl_code input 4, the colour code of all overlay cells.
REQ-012 SHALL have o_vs, o_hs and o_de outputs 1 each, the input syncs delayed by 2 cycles.
REQ-013 SHALL have o_red, o_grn and o_blu outputs 8 each, the pixel colour aligned with o_de.

Function
REQ-014 SHALL increment pixel counter x on each cycle with i_de=1, and clear x to 0 on the first cycle with i_de=0.
REQ-015 SHALL increment line counter y on each i_de falling edge, and clear y to 0 while i_vs=1.
- Both counters are 11 bits and saturate at 2047.
REQ-016 SHALL latch i_board, i_ovl_x, i_ovl_y and i_ovl_code into shadow registers on the cycle i_vs rises; rendering uses only the shadow copies, so mid-frame input changes never tear.
REQ-017 Stage 1 SHALL register the cell column cx=(x-ORG_X)>>CELL_LOG2 and row cy=(y-ORG_Y)>>CELL_LOG2, plus an inside flag.
- inside = x>=ORG_X, y>=ORG_Y, cx<COLS and cy<ROWS.
REQ-018 Stage 2 SHALL resolve the code by priority, then register RGB from the palette:
- not inside -> border (200,200,200);
- any overlay entry k matching (cx,cy) -> shadow i_ovl_code;
- shadow board cell nonzero -> that code;
- otherwise -> code 0.
REQ-019 SHALL ignore an overlay entry whose x>=COLS or y>=ROWS, so it matches no cell.
REQ-020 The palette SHALL be fixed:
- 0=(0,0,0), 1=(0,255,255), 2=(255,255,0), 3=(255,0,255), 4=(255,127,0), 5=(0,0,255), 6=(0,255,0), 7=(255,0,0);
- codes 8-15 = (127,127,127).
REQ-021 SHALL force RGB to 0 when the stage-2 delayed de is 0.
REQ-022 SHALL keep o_vs, o_hs and o_de exactly 2 cycles behind i_vs, i_hs and i_de with no gaps.

Reset
REQ-023 On rst_n=0, all outputs, both counters, all pipeline registers and all shadow registers SHALL go to 0 asynchronously.
REQ-024 After release, output SHALL stay black until the first i_vs rise loads the shadows.
- Reset mid-frame restarts counting at x=0, y=0.

Configuration
REQ-025 With macro GRID_RENDER_GRIDLINE_EN defined:
- inside pixels whose low CELL_LOG2 bits of (x-ORG_X) or of (y-ORG_Y) are all 0 SHALL render (64,64,64), overriding board and overlay but not border.
- Without the macro, no grid lines are drawn and REQ-018 applies unchanged.

Verification
REQ-026 Board all zero, overlay at (31,31), one 1024x768 frame -> pixel (0,0) is (0,0,0); pixel (320,0) is (200,200,200); o_de equals i_de delayed by 2 cycles on every cycle.
REQ-027 Board cell (3,2)=7, overlay entry 0 at (3,2), i_ovl_code=1 -> pixels x 96..127, y 64..95 are (0,255,255), overlay winning.
REQ-028 Change board cell (0,0) from 0 to 5 while y=100 mid-frame -> current frame keeps (0,0,0) at (0,0); next frame shows (0,0,255).
REQ-029 ORG_X=64, COLS=4 -> x=63 is border, x=64 is cell 0, x=191 is cell 3, x=192 is border.
REQ-030 Assert rst_n=0 for 3 cycles at x=500 -> all outputs go 0 immediately; after release, output is black until the next i_vs rise, then renders normally.
REQ-031 With GRID_RENDER_GRIDLINE_EN defined and board cell (1,1)=3 -> pixel (32,40) is (64,64,64) and (33,40) is (255,0,255).
